// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller driving a single full adder LSB-first

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [WIDTH-2:0] sh_s_q, sh_s_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_c, last;
    logic [WIDTH-1:0] acc;

    full_adder u_fa (
        .a_i (sh_a_q[0]),
        .b_i (sh_b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    assign last = (cnt_q == CW'(WIDTH - 1));
    // Completed bits so far with the current sum bit entering at the MSB end.
    assign acc  = {fa_s, sh_s_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE);
        busy  = (state_q == RUN);
        done  = (state_q == DONE);
    end

    always_comb begin
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        sh_s_d  = sh_s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_a_d  = a;
                    sh_b_d  = b;
                    sh_s_d  = '0;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                sh_a_d  = {1'b0, sh_a_q[WIDTH-1:1]};
                sh_b_d  = {1'b0, sh_b_q[WIDTH-1:1]};
                sh_s_d  = acc[WIDTH-1:1];
                carry_d = fa_c;
                if (last) begin
                    sum_d  = acc;
                    cout_d = fa_c;
                    cnt_d  = '0;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            sh_s_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            sh_s_q  <= sh_s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl at WIDTH 8, 16 and 2

module tb_serial_add_ctrl;
    logic        clk, rst_n;
    logic [2:0]  st, ci, rdy, bsy, dn, co;
    logic [63:0] av [3];
    logic [63:0] bv [3];
    logic [7:0]  s8;
    logic [15:0] s16;
    logic [1:0]  s2;
    int          wd [3] = '{8, 16, 2};
    int          errors = 0;
    int          checks = 0;
    logic [64:0] exp_q [$];

    serial_add_ctrl #(.WIDTH(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0][7:0]), .b(bv[0][7:0]), .cin(ci[0]),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .sum(s8), .cout(co[0]));
    serial_add_ctrl #(.WIDTH(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1][15:0]), .b(bv[1][15:0]), .cin(ci[1]),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .sum(s16), .cout(co[1]));
    serial_add_ctrl #(.WIDTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2][1:0]), .b(bv[2][1:0]), .cin(ci[2]),
        .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .sum(s2), .cout(co[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [64:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic c);
        logic [63:0] m;
        logic [64:0] f;
        m = (64'd1 << w) - 64'd1;
        f = {1'b0, x & m} + {1'b0, y & m} + {64'd0, c};
        return {f[w], f[63:0] & m};
    endfunction

    function automatic logic [64:0] result(input int i);
        logic [63:0] s;
        s = (i == 0) ? {56'd0, s8} : (i == 1) ? {48'd0, s16} : {62'd0, s2};
        return {co[i], s};
    endfunction

    // One add on instance i; poke drives a stray start at that RUN cycle, poke_done does so in DONE.
    task automatic op(input int i, input logic [63:0] x, input logic [63:0] y, input logic c,
                      input int poke, input bit poke_done, input string nm);
        int cyc, nb;
        logic [64:0] e;
        av[i] = x; bv[i] = y; ci[i] = c; st[i] = 1'b1;
        exp_q.push_back(model(wd[i], x, y, c));
        @(negedge clk);
        st[i] = 1'b0; cyc = 1; nb = 0;
        while (!dn[i] && cyc <= 3 * wd[i]) begin
            if (bsy[i]) nb++;
            if (cyc == poke) begin
                st[i] = 1'b1; av[i] = ~x; bv[i] = ~y; ci[i] = ~c;
            end else begin
                st[i] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== wd[i] + 1) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", nm, cyc, wd[i] + 1);
        end
        checks++;
        if (nb !== wd[i]) begin
            errors++; $display("FAIL %s busy cycles: got %0d want %0d", nm, nb, wd[i]);
        end
        e = exp_q.pop_front();
        checks++;
        if (result(i) !== e) begin
            errors++; $display("FAIL %s result: got %h want %h", nm, result(i), e);
        end
        if (poke_done) begin
            st[i] = 1'b1; av[i] = 64'h1; bv[i] = 64'h1; ci[i] = 1'b1;
        end
        @(negedge clk);
        st[i] = 1'b0;
        checks++;
        if (dn[i] !== 1'b0 || rdy[i] !== 1'b1 || bsy[i] !== 1'b0) begin
            errors++; $display("FAIL %s after done: got done=%b ready=%b busy=%b want 0 1 0",
                               nm, dn[i], rdy[i], bsy[i]);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({rdy[i], bsy[i], dn[i]} !== 3'b100 || result(i) !== 65'd0) begin
                errors++; $display("FAIL reset[%0d]: got rdy/bsy/dn=%b%b%b res=%h want 100 0",
                                   i, rdy[i], bsy[i], dn[i], result(i));
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        op(0, 64'h5A, 64'h3C, 1'b0, 0, 1'b0, "t1_5a_3c");
        checks++;
        if ({co[0], s8} !== 9'h096) begin
            errors++; $display("FAIL t1_value: got %h want 096", {co[0], s8});
        end
    endtask

    task automatic test_carry_hold;
        op(0, 64'hFF, 64'h01, 1'b0, 0, 1'b0, "t2_ff_01");
        repeat (3) @(negedge clk);
        checks++;
        if ({co[0], s8} !== 9'h100) begin
            errors++; $display("FAIL t2_hold: got %h want 100", {co[0], s8});
        end
        op(0, 64'hFF, 64'hFF, 1'b1, 0, 1'b0, "t2_ff_ff_1");
        checks++;
        if ({co[0], s8} !== 9'h1FF) begin
            errors++; $display("FAIL t2_value: got %h want 1ff", {co[0], s8});
        end
    endtask

    task automatic test_back_to_back;
        bit prevd;
        int lastd, nres, n;
        logic [64:0] e;
        prevd = 1'b0; lastd = -1; nres = 0;
        st[0] = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (dn[0]) begin
                nres++;
                e = exp_q.pop_front();
                checks++;
                if (result(0) !== e) begin
                    errors++; $display("FAIL t3_result: got %h want %h", result(0), e);
                end
                checks++;
                if (prevd) begin
                    errors++; $display("FAIL t3_done_width: got 2 cycles want 1");
                end
                if (lastd >= 0) begin
                    checks++;
                    if (cyc - lastd !== 10) begin
                        errors++; $display("FAIL t3_spacing: got %0d want 10", cyc - lastd);
                    end
                end
                lastd = cyc;
            end
            prevd = dn[0];
            av[0] = 64'($urandom); bv[0] = 64'($urandom); ci[0] = 1'($urandom);
            if (rdy[0]) exp_q.push_back(model(8, av[0], bv[0], ci[0]));
            @(negedge clk);
        end
        st[0] = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 30) begin
            if (dn[0]) begin
                e = exp_q.pop_front();
                checks++;
                if (result(0) !== e) begin
                    errors++; $display("FAIL t3_drain: got %h want %h", result(0), e);
                end
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || nres < 5) begin
            errors++; $display("FAIL t3_count: got %0d results, %0d pending want >=5, 0",
                               nres, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ignore_start;
        op(0, 64'h12, 64'h34, 1'b1, 3, 1'b0, "t4_mid_run");
        op(0, 64'hC3, 64'h7E, 1'b0, 0, 1'b1, "t4_in_done");
    endtask

    task automatic test_reset_mid_run;
        int seen;
        av[0] = 64'hAA; bv[0] = 64'h55; ci[0] = 1'b1; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy[0], bsy[0], dn[0]} !== 3'b100 || result(0) !== 65'd0) begin
            errors++; $display("FAIL t5_async: got rdy/bsy/dn=%b%b%b res=%h want 100 0",
                               rdy[0], bsy[0], dn[0], result(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            if (dn[0]) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL t5_no_done: got %0d pulses want 0", seen);
        end
        op(0, 64'h80, 64'h80, 1'b1, 0, 1'b0, "t5_fresh");
    endtask

    task automatic test_random;
        for (int i = 1; i < 3; i++) begin
            op(i, 64'd0, 64'd0, 1'b0, 0, 1'b0, "t6_zero");
            op(i, '1, '1, 1'b1, 0, 1'b0, "t6_ones");
            for (int k = 0; k < 1000; k++)
                op(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 0, 1'b0, "t6_rand");
        end
    endtask

    initial begin
        st = '0; ci = '0;
        for (int i = 0; i < 3; i++) begin
            av[i] = '0; bv[i] = '0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_carry_hold;
        test_back_to_back;
        test_ignore_start;
        test_reset_mid_run;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
